// File: rtl/lcd_fb_arb.sv
// lcd_fb_arb: display-priority framebuffer SRAM arbiter with host starvation guard (optional via LCD_FB_ARB_STARVE_EN)
module lcd_fb_arb #(
  parameter int AW = 17,
  parameter int DW = 16,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_forced,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
  state_t r_state, w_state_nxt;
  logic w_override;
  logic r_rd1, r_rd2;
`ifdef LCD_FB_ARB_STARVE_EN
  localparam int CW = $clog2(HOST_MAX_WAIT + 1);
  logic [CW-1:0] r_wait_cnt;
  // count cycles a host request sits ungranted, saturating at the limit
  always_ff @(posedge clk)
    if (rst || !host_req || host_gnt) r_wait_cnt <= '0;
    else if (r_wait_cnt != CW'(HOST_MAX_WAIT)) r_wait_cnt <= r_wait_cnt + 1'b1;
  assign w_override = r_wait_cnt == CW'(HOST_MAX_WAIT);
`else
  assign w_override = HOST_MAX_WAIT < 0;
`endif
  // grants from last transfer type; a write forces one turnaround cycle before a read
  always_comb begin
    disp_gnt = 1'b0;
    host_gnt = 1'b0;
    host_forced = 1'b0;
    if (!rst) begin
      if (r_state == S_WR) host_gnt = host_req && !disp_req;
      else if (w_override && host_req) begin
        host_gnt = 1'b1;
        host_forced = disp_req;
      end
      else if (disp_req) disp_gnt = 1'b1;
      else host_gnt = host_req;
    end
    w_state_nxt = disp_gnt ? S_RD : host_gnt ? S_WR : S_IDLE;
  end
  // remember the type of the transfer just made
  always_ff @(posedge clk)
    r_state <= rst ? S_IDLE : w_state_nxt;
  // register the winning transfer toward the SRAM
  always_ff @(posedge clk)
    if (rst) begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= disp_gnt || host_gnt;
      mem_we <= host_gnt;
      if (disp_gnt) mem_addr <= disp_addr;
      else if (host_gnt) mem_addr <= host_addr;
      if (host_gnt) mem_wdata <= host_wdata;
    end
  // two-stage read flag aligns the return pulse with SRAM data
  always_ff @(posedge clk)
    if (rst) begin
      r_rd1 <= 1'b0;
      r_rd2 <= 1'b0;
      disp_rvalid <= 1'b0;
      disp_rdata <= '0;
    end else begin
      r_rd1 <= disp_gnt;
      r_rd2 <= r_rd1;
      disp_rvalid <= r_rd2;
      if (r_rd2) disp_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_lcd_fb_arb.sv
// tb_lcd_fb_arb: directed self-checking bench for lcd_fb_arb
module tb_lcd_fb_arb;
  logic clk = 1'b0;
  logic rst;
  logic disp_req, disp_gnt, disp_rvalid;
  logic [16:0] disp_addr;
  logic [15:0] disp_rdata;
  logic host_req, host_gnt, host_forced;
  logic [16:0] host_addr;
  logic [15:0] host_wdata;
  logic mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] tmem [0:63];
  logic [63:0] tval = '0;
  int n_checks = 0;
  int n_pass = 0;

  lcd_fb_arb #(.AW(17), .DW(16), .HOST_MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_forced(host_forced),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: 1-cycle read latency; unwritten words return a fixed pattern
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) begin
        tmem[mem_addr[5:0]] <= mem_wdata;
        tval[mem_addr[5:0]] <= 1'b1;
      end else
        mem_rdata <= tval[mem_addr[5:0]] ? tmem[mem_addr[5:0]] :
                     (mem_addr[5:0] == 6'h10) ? 16'hF800 : {10'h155, mem_addr[5:0]};
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    disp_req = 1'b1;
    host_req = 1'b1;
    disp_addr = 17'h3;
    host_addr = 17'h7;
    host_wdata = 16'hABCD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_grants", {disp_gnt, host_gnt, host_forced}, 3'b000);
      chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, '0);
      chk("rst_rd", {disp_rvalid, disp_rdata}, '0);
    end
    next_cycle();
    rst = 1'b0;
    disp_req = 1'b0;
    host_req = 1'b0;
    repeat (3) next_cycle();
  endtask

  task automatic test_single_read;
    disp_req = 1'b1;
    disp_addr = 17'h00010;
    @(negedge clk);
    chk("rd_gnt", {disp_gnt, host_gnt}, 2'b10);
    next_cycle();
    disp_req = 1'b0;
    @(negedge clk);
    chk("rd_mem", {mem_en, mem_we, mem_addr}, {2'b10, 17'h10});
    chk("rd_early1", disp_rvalid, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("rd_early2", disp_rvalid, 1'b0);
    chk("rd_memidle", mem_en, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("rd_ret", {disp_rvalid, disp_rdata}, {1'b1, 16'hF800});
    next_cycle();
    @(negedge clk);
    chk("rd_pulse", disp_rvalid, 1'b0);
    repeat (2) next_cycle();
  endtask

  task automatic test_write_read;
    host_req = 1'b1;
    host_addr = 17'd5;
    host_wdata = 16'h07E0;
    @(negedge clk);
    chk("wr_gnt", {disp_gnt, host_gnt, host_forced}, 3'b010);
    next_cycle();
    host_req = 1'b0;
    disp_req = 1'b1;
    disp_addr = 17'd5;
    @(negedge clk);
    chk("wr_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 17'd5, 16'h07E0});
    chk("wr_turn", disp_gnt, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("wr_then_rd", disp_gnt, 1'b1);
    chk("wr_idle_mem", mem_en, 1'b0);
    next_cycle();
    disp_req = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("wr_readback", {disp_rvalid, disp_rdata}, {1'b1, 16'h07E0});
    repeat (2) next_cycle();
  endtask

  task automatic test_starvation;
    disp_req = 1'b1;
    host_req = 1'b1;
    disp_addr = 17'h20;
    host_addr = 17'h21;
    host_wdata = 16'h1234;
`ifdef LCD_FB_ARB_STARVE_EN
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c < 8) chk("stv_disp", {disp_gnt, host_gnt, host_forced}, 3'b100);
      else if (c == 8) chk("stv_force", {disp_gnt, host_gnt, host_forced}, 3'b011);
      else if (c == 9) chk("stv_turn", {disp_gnt, host_gnt, host_forced}, 3'b000);
      else chk("stv_resume", {disp_gnt, host_gnt, host_forced}, 3'b100);
      next_cycle();
    end
`else
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("stv_strict", {disp_gnt, host_gnt, host_forced}, 3'b100);
      next_cycle();
    end
`endif
    disp_req = 1'b0;
    @(negedge clk);
    chk("stv_host_free", {disp_gnt, host_gnt, host_forced}, 3'b010);
    next_cycle();
    host_req = 1'b0;
    repeat (4) next_cycle();
  endtask

  task automatic test_back_to_back;
    host_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_addr = 17'(i);
      host_wdata = 16'(16'hA000 + i);
      @(negedge clk);
      chk("b2b_gnt", host_gnt, 1'b1);
      if (i > 0) chk("b2b_mem", {mem_en, mem_we, mem_addr}, {2'b11, 17'(i - 1)});
      next_cycle();
    end
    host_req = 1'b0;
    @(negedge clk);
    chk("b2b_last", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 17'd3, 16'hA003});
    chk("b2b_nognt", host_gnt, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("b2b_done", mem_en, 1'b0);
    next_cycle();
  endtask

  task automatic test_reset_mid_read;
    disp_req = 1'b1;
    disp_addr = 17'h10;
    @(negedge clk);
    chk("mrst_gnt", disp_gnt, 1'b1);
    next_cycle();
    disp_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    disp_req = 1'b1;
    @(negedge clk);
    chk("mrst_gnt_rst", disp_gnt, 1'b0);
    next_cycle();
    rst = 1'b0;
    disp_req = 1'b0;
    @(negedge clk);
    chk("mrst_flush", {disp_rvalid, mem_en}, 2'b00);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      chk("mrst_quiet", disp_rvalid, 1'b0);
    end
    next_cycle();
    disp_req = 1'b1;
    disp_addr = 17'd2;
    @(negedge clk);
    chk("mrst_regnt", disp_gnt, 1'b1);
    next_cycle();
    disp_req = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("mrst_ret", {disp_rvalid, disp_rdata}, {1'b1, 16'hA002});
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_starvation();
    test_back_to_back();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
